// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: modulus, Barrett parameters and coefficient/product widths.
// Used by both the Karatsuba multiplier and the Barrett reducer.
package ntt_pkg;
  localparam int unsigned Q         = 3329;
  localparam int unsigned BARRETT_K = 24;
  localparam int unsigned BARRETT_M = 5039;
  localparam int unsigned COEF_W    = 12;
  localparam int unsigned PROD_W    = 24;
  localparam int unsigned QUOT_W    = 13;
  localparam int unsigned TAG_W     = 8;
endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline register: data plus valid bit, loaded when en_i, held otherwise.
// Asynchronous active-high reset clears both valid and data.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/mod_reduce_pipe.sv
// Three-stage Barrett reducer: 24-bit product -> product mod Q, tag carried alongside,
// valid/ready handshake with a combinational enable chain so backpressure stalls every stage.
module mod_reduce_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned W_IN  = PROD_W,
  parameter int unsigned W_OUT = COEF_W,
  parameter int unsigned TAG_W = ntt_pkg::TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [W_IN-1:0]  prod_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [W_OUT-1:0] res_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int unsigned S1_W = TAG_W + 2 * QUOT_W;
  localparam int unsigned S2_W = TAG_W + QUOT_W;
  localparam int unsigned S3_W = TAG_W + W_OUT;

  localparam logic [QUOT_W-1:0] M_R = QUOT_W'(BARRETT_M);
  localparam logic [QUOT_W-1:0] Q_R = QUOT_W'(Q);

  logic v1, v2, v3;
  logic en1, en2, en3;

  logic [W_IN+QUOT_W-1:0] xm;
  logic [QUOT_W-1:0]      t_d, r_d;
  logic [W_OUT-1:0]       res_d;

  logic [S1_W-1:0] s1_in, s1_data;
  logic [S2_W-1:0] s2_in, s2_data;
  logic [S3_W-1:0] s3_in, s3_data;

  logic [TAG_W-1:0]  s1_tag, s2_tag;
  logic [QUOT_W-1:0] s1_x, s1_t, s2_r;

  always_comb begin
    en3 = ~v3 | ready_i;
    en2 = ~v2 | en3;
    en1 = ~v1 | en2;
  end

  assign ready_o = en1;

  assign {s1_tag, s1_x, s1_t} = s1_data;
  assign {s2_tag, s2_r}       = s2_data;

  always_comb begin
    xm  = {{QUOT_W{1'b0}}, prod_i} * {{W_IN{1'b0}}, M_R};
    t_d = QUOT_W'(xm >> BARRETT_K);
    // r = x - t*Q is known to be below 2^13, so only the low 13 bits of x
    // are carried forward and the subtraction wraps harmlessly in 13 bits.
    r_d = s1_x - s1_t * Q_R;
    res_d = (s2_r >= Q_R) ? W_OUT'(s2_r - Q_R) : W_OUT'(s2_r);
    s1_in = {tag_i, prod_i[QUOT_W-1:0], t_d};
    s2_in = {s1_tag, r_d};
    s3_in = {s2_tag, res_d};
  end

  pipe_stage #(.W(S1_W)) u_stage1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en1),
    .valid_i (valid_i),
    .data_i  (s1_in),
    .valid_o (v1),
    .data_o  (s1_data)
  );

  pipe_stage #(.W(S2_W)) u_stage2 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en2),
    .valid_i (v1),
    .data_i  (s2_in),
    .valid_o (v2),
    .data_o  (s2_data)
  );

  pipe_stage #(.W(S3_W)) u_stage3 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en3),
    .valid_i (v2),
    .data_i  (s3_in),
    .valid_o (v3),
    .data_o  (s3_data)
  );

  assign valid_o        = v3;
  assign {tag_o, res_o} = s3_data;
endmodule
